// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width for n items, never less than 1 bit.
    function automatic int clog2w(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 30; i++) begin
            if ((1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req after ptr, wrapping modulo N.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int LW = clog2w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [LW-1:0] ptr,
    output logic [LW-1:0] gnt_idx,
    output logic          any
);

    int idx;

    // Walk from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) begin
                gnt_idx = LW'(idx);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Packet-atomic round-robin arbiter feeding a single-clock FIFO write port.
// Optional stall timeout enabled by defining FIFO_ARB_TIMEOUT_EN.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 16,
    parameter int TO = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           req_v,
    input  logic [N*W-1:0]         req_d,
    input  logic [N-1:0]           req_last,
    output logic [N-1:0]           req_rdy,
    output logic                   fifo_write,
    output logic [W-1:0]           fifo_data_in,
    input  logic                   fifo_full,
    output logic [clog2w(N)-1:0]   grant_id,
    output logic                   busy,
    output logic                   to_err
);

    localparam int LW = clog2w(N);

    arb_state_e    state_q;
    logic [LW-1:0] ptr_q;
    logic [LW-1:0] grant_q;
    logic [LW-1:0] pick_idx;
    logic          pick_any;
    logic          beat;

    rr_pick #(.N(N)) u_pick (
        .req     (req_v),
        .ptr     (ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    assign busy         = (state_q == GRANT);
    assign grant_id     = grant_q;
    assign beat         = busy & req_v[grant_q] & ~fifo_full;
    assign fifo_write   = beat;
    assign fifo_data_in = req_d[int'(grant_q)*W +: W];

    always_comb begin
        req_rdy = '0;
        if (busy) req_rdy[grant_q] = ~fifo_full;
    end

`ifdef FIFO_ARB_TIMEOUT_EN
    localparam int CW = clog2w(TO);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stall;

    // Only an idle owner counts; a full FIFO is not the owner's fault.
    assign stall  = busy & ~req_v[grant_q] & ~fifo_full;
    assign to_err = stall && (cnt_q == CW'(TO - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!busy || beat || to_err) cnt_d = '0;
        else if (stall)              cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign to_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= LW'(N - 1);
            grant_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if ((beat && req_last[grant_q]) || to_err) begin
                        ptr_q   <= grant_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb: vector table plus hand-written corner sequences.
module tb_fifo_wr_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_v;
    logic [63:0] req_d;
    logic [3:0]  req_last;
    logic [3:0]  req_rdy;
    logic        fifo_write;
    logic [15:0] fifo_data_in;
    logic        fifo_full;
    logic [1:0]  grant_id;
    logic        busy;
    logic        to_err;

    int n_cmp;
    int n_bad;

    fifo_wr_arb #(.N(4), .W(16), .TO(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_v        (req_v),
        .req_d        (req_d),
        .req_last     (req_last),
        .req_rdy      (req_rdy),
        .fifo_write   (fifo_write),
        .fifo_data_in (fifo_data_in),
        .fifo_full    (fifo_full),
        .grant_id     (grant_id),
        .busy         (busy),
        .to_err       (to_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  l;
        logic        f;
        logic [63:0] d;
        logic [3:0]  rdy;
        logic        wr;
        logic [15:0] dat;
        logic        bsy;
        logic [1:0]  gid;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                         input logic f, input logic [63:0] d);
        @(negedge clk);
        rst_n    = r;
        req_v    = v;
        req_last = l;
        fifo_full = f;
        req_d    = d;
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [3:0] rdy, input logic wr,
                              input logic [15:0] dat, input logic bsy, input logic [1:0] gid,
                              input logic terr);
        chk({nm, ".rdy"},   32'(req_rdy),    32'(rdy));
        chk({nm, ".write"}, 32'(fifo_write), 32'(wr));
        chk({nm, ".busy"},  32'(busy),       32'(bsy));
        chk({nm, ".to_err"}, 32'(to_err),    32'(terr));
        if (wr)  chk({nm, ".data"}, 32'(fifo_data_in), 32'(dat));
        if (bsy) chk({nm, ".gid"},  32'(grant_id),     32'(gid));
    endtask

    localparam logic [63:0] DB = 64'h00B3_00B2_00B1_00B0;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req_v = '0;
        req_last = '0;
        req_d = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);

        //            rst v     l     f  d        rdy   wr dat     bsy gid
        tbl[0]  = '{1'b0, 4'h0, 4'h0, 1'b0, 64'h0,  4'h0, 1'b0, 16'h0,  1'b0, 2'd0};
        tbl[1]  = '{1'b1, 4'h1, 4'h0, 1'b0, 64'hA1, 4'h0, 1'b0, 16'h0,  1'b0, 2'd0};
        tbl[2]  = '{1'b1, 4'h1, 4'h0, 1'b0, 64'hA1, 4'h1, 1'b1, 16'hA1, 1'b1, 2'd0};
        tbl[3]  = '{1'b1, 4'h1, 4'h0, 1'b0, 64'hA2, 4'h1, 1'b1, 16'hA2, 1'b1, 2'd0};
        tbl[4]  = '{1'b1, 4'h1, 4'h1, 1'b0, 64'hA3, 4'h1, 1'b1, 16'hA3, 1'b1, 2'd0};
        tbl[5]  = '{1'b1, 4'h0, 4'h0, 1'b0, 64'h0,  4'h0, 1'b0, 16'h0,  1'b0, 2'd0};
        tbl[6]  = '{1'b0, 4'h0, 4'h0, 1'b0, 64'h0,  4'h0, 1'b0, 16'h0,  1'b0, 2'd0};
        tbl[7]  = '{1'b1, 4'hF, 4'hF, 1'b0, DB,     4'h0, 1'b0, 16'h0,  1'b0, 2'd0};
        tbl[8]  = '{1'b1, 4'hF, 4'hF, 1'b0, DB,     4'h1, 1'b1, 16'hB0, 1'b1, 2'd0};
        tbl[9]  = '{1'b1, 4'hF, 4'hF, 1'b0, DB,     4'h0, 1'b0, 16'h0,  1'b0, 2'd0};
        tbl[10] = '{1'b1, 4'hF, 4'hF, 1'b0, DB,     4'h2, 1'b1, 16'hB1, 1'b1, 2'd1};
        tbl[11] = '{1'b1, 4'hF, 4'hF, 1'b0, DB,     4'h0, 1'b0, 16'h0,  1'b0, 2'd0};
        tbl[12] = '{1'b1, 4'hF, 4'hF, 1'b0, DB,     4'h4, 1'b1, 16'hB2, 1'b1, 2'd2};
        tbl[13] = '{1'b1, 4'hF, 4'hF, 1'b0, DB,     4'h0, 1'b0, 16'h0,  1'b0, 2'd0};
        tbl[14] = '{1'b1, 4'hF, 4'hF, 1'b0, DB,     4'h8, 1'b1, 16'hB3, 1'b1, 2'd3};
        tbl[15] = '{1'b1, 4'hF, 4'hF, 1'b0, DB,     4'h0, 1'b0, 16'h0,  1'b0, 2'd0};
        tbl[16] = '{1'b1, 4'hF, 4'hF, 1'b0, DB,     4'h1, 1'b1, 16'hB0, 1'b1, 2'd0};
        tbl[17] = '{1'b1, 4'h0, 4'h0, 1'b0, 64'h0,  4'h0, 1'b0, 16'h0,  1'b0, 2'd0};

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].l, tbl[i].f, tbl[i].d);
            expect_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].wr, tbl[i].dat,
                       tbl[i].bsy, tbl[i].gid, 1'b0);
        end

        // Requester 2 packet with a 5-cycle FIFO-full stall mid-packet.
        drive(1, 4'h4, 4'h0, 0, 64'h00C1_0000_0000);
        expect_out("full.arb", 4'h0, 0, 16'h0, 0, 2'd0, 0);
        drive(1, 4'h4, 4'h0, 0, 64'h00C1_0000_0000);
        expect_out("full.b1", 4'h4, 1, 16'hC1, 1, 2'd2, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'h4, 4'h0, 1, 64'h00C2_0000_0000);
            expect_out($sformatf("full.stall%0d", i), 4'h0, 0, 16'h0, 1, 2'd2, 0);
        end
        drive(1, 4'h4, 4'h0, 0, 64'h00C2_0000_0000);
        expect_out("full.b2", 4'h4, 1, 16'hC2, 1, 2'd2, 0);
        drive(1, 4'h4, 4'h4, 0, 64'h00C3_0000_0000);
        expect_out("full.b3", 4'h4, 1, 16'hC3, 1, 2'd2, 0);
        drive(1, 4'h0, 4'h0, 0, 64'h0);
        expect_out("full.done", 4'h0, 0, 16'h0, 0, 2'd0, 0);

        // Requester 1 drops valid mid-packet while requester 3 waits.
        drive(1, 4'h2, 4'h0, 0, 64'h00E1_0000_00D1_0000);
        expect_out("hold.arb", 4'h0, 0, 16'h0, 0, 2'd0, 0);
        drive(1, 4'hA, 4'h0, 0, 64'h00E1_0000_00D1_0000);
        expect_out("hold.b1", 4'h2, 1, 16'hD1, 1, 2'd1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'h8, 4'h0, 0, 64'h00E1_0000_00D2_0000);
            expect_out($sformatf("hold.gap%0d", i), 4'h2, 0, 16'h0, 1, 2'd1, 0);
        end
        drive(1, 4'hA, 4'h2, 0, 64'h00E1_0000_00D2_0000);
        expect_out("hold.last", 4'h2, 1, 16'hD2, 1, 2'd1, 0);
        drive(1, 4'h8, 4'h8, 0, 64'h00E1_0000_0000_0000);
        expect_out("hold.arb3", 4'h0, 0, 16'h0, 0, 2'd0, 0);
        drive(1, 4'h8, 4'h8, 0, 64'h00E1_0000_0000_0000);
        expect_out("hold.g3", 4'h8, 1, 16'hE1, 1, 2'd3, 0);
        drive(1, 4'h0, 4'h0, 0, 64'h0);
        expect_out("hold.done", 4'h0, 0, 16'h0, 0, 2'd0, 0);

        // Requester 0 stalls mid-packet with requester 1 waiting behind it.
        drive(1, 4'h3, 4'h0, 0, 64'h0000_0000_0000_00F1);
        expect_out("to.arb", 4'h0, 0, 16'h0, 0, 2'd0, 0);
        drive(1, 4'h3, 4'h0, 0, 64'h0000_0000_0000_00F1);
        expect_out("to.b1", 4'h1, 1, 16'hF1, 1, 2'd0, 0);
`ifdef FIFO_ARB_TIMEOUT_EN
        for (int i = 1; i <= 7; i++) begin
            drive(1, 4'h2, 4'h2, 0, 64'h0000_0000_0091_0000);
            expect_out($sformatf("to.stall%0d", i), 4'h1, 0, 16'h0, 1, 2'd0, 0);
        end
        drive(1, 4'h2, 4'h2, 0, 64'h0000_0000_0091_0000);
        expect_out("to.pulse", 4'h1, 0, 16'h0, 1, 2'd0, 1);
        drive(1, 4'h2, 4'h2, 0, 64'h0000_0000_0091_0000);
        expect_out("to.idle", 4'h0, 0, 16'h0, 0, 2'd0, 0);
        drive(1, 4'h2, 4'h2, 0, 64'h0000_0000_0091_0000);
        expect_out("to.g1", 4'h2, 1, 16'h91, 1, 2'd1, 0);
`else
        for (int i = 1; i <= 10; i++) begin
            drive(1, 4'h2, 4'h2, 0, 64'h0000_0000_0091_0000);
            expect_out($sformatf("to.hold%0d", i), 4'h1, 0, 16'h0, 1, 2'd0, 0);
        end
        drive(1, 4'h1, 4'h1, 0, 64'h0000_0000_0000_00F2);
        expect_out("to.b2", 4'h1, 1, 16'hF2, 1, 2'd0, 0);
`endif
        drive(1, 4'h0, 4'h0, 0, 64'h0);
        expect_out("to.done", 4'h0, 0, 16'h0, 0, 2'd0, 0);

        // Reset in the middle of a requester 2 packet.
        drive(1, 4'h4, 4'h0, 0, 64'h0055_0000_0000);
        expect_out("rst.arb", 4'h0, 0, 16'h0, 0, 2'd0, 0);
        drive(1, 4'h4, 4'h0, 0, 64'h0055_0000_0000);
        expect_out("rst.b1", 4'h4, 1, 16'h55, 1, 2'd2, 0);
        drive(0, 4'h4, 4'h0, 0, 64'h0056_0000_0000);
        drive(0, 4'h4, 4'h0, 0, 64'h0056_0000_0000);
        expect_out("rst.held", 4'h0, 0, 16'h0, 0, 2'd0, 0);
        drive(1, 4'hF, 4'hF, 0, DB);
        expect_out("rst.arb0", 4'h0, 0, 16'h0, 0, 2'd0, 0);
        drive(1, 4'hF, 4'hF, 0, DB);
        expect_out("rst.g0", 4'h1, 1, 16'hB0, 1, 2'd0, 0);
        drive(1, 4'h0, 4'h0, 0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameter N, default 4: number of requesters, range 2..16.
REQ-002 Parameter W, default 16: data width, matching the downstream single-clock FIFO data_in.
REQ-003 Parameter TO, default 256: stall-timeout cycles, used only when FIFO_ARB_TIMEOUT_EN is defined.
REQ-004 clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 req_v  input  N  per-requester beat valid.
REQ-007 req_d  input  N*W  per-requester data, flattened; requester i occupies bits [i*W +: W].
REQ-008 req_last  input  N  per-requester end-of-packet marker, qualified by req_v.
REQ-009 req_rdy  output  N  per-requester beat accept.
REQ-010 fifo_write  output  1  write strobe to the FIFO.
REQ-011 fifo_data_in  output  W  write data to the FIFO.
REQ-012 fifo_full  input  1  FIFO full flag.
REQ-013 grant_id  output  $clog2(N)  index of the current owner; valid while busy=1.
REQ-014 busy  output  1  a packet grant is held.
REQ-015 to_err  output  1  one-cycle pulse on a stall timeout.

Function
REQ-016 The block shall be a two-state FSM: IDLE and GRANT.
REQ-017 IDLE: if any req_v is high, the block shall latch the winner into grant_id and enter GRANT on the next edge; this is a one-cycle arbitration bubble and no beat is accepted in IDLE.
REQ-018 Winner selection shall be round-robin: the first requester with req_v=1, searching ptr+1, ptr+2, ... modulo N.
REQ-019 GRANT: req_rdy[grant_id] shall equal !fifo_full; every other req_rdy bit shall be 0.
REQ-020 A beat transfers when req_v[g] & req_rdy[g]; that same cycle, combinationally, fifo_write=1 and fifo_data_in=req_d[g] (zero latency).
REQ-021 fifo_write shall never assert while fifo_full=1, so no FIFO write is ever dropped.
REQ-022 On a transferred beat with req_last[g]=1, the block shall set ptr<=g and enter IDLE on the next edge.
REQ-023 Deasserting req_v mid-packet shall not release the grant; the packet stays atomic.
REQ-024 A single-beat packet (req_v and req_last both high on the first GRANT cycle) shall complete in one GRANT cycle.
REQ-025 When fifo_data_in is not driven by a transferring beat, it shall hold the granted requester's data and is don't-care for the FIFO.
REQ-026 busy shall be 1 exactly in GRANT.

Reset
REQ-027 While rst_n=0 at an edge, the block shall set: state=IDLE, ptr=N-1 (requester 0 wins first), grant_id=0, timeout counter=0.
REQ-028 During reset, outputs shall be: req_rdy=0, fifo_write=0, busy=0, to_err=0, from the first edge with rst_n=0.
REQ-029 Reset asserted mid-packet shall abandon the packet with no further write; recovering the packet is the upstream's responsibility.

Configuration
REQ-030 Macro FIFO_ARB_TIMEOUT_EN.
REQ-031 With the macro defined, a counter shall count GRANT cycles where req_v[g]=0 and fifo_full=0.
REQ-032 That counter shall clear on any transferred beat, and does not count while fifo_full=1.
REQ-033 When the counter reaches TO-1, the block shall pulse to_err for one cycle, set ptr<=g and enter IDLE.
REQ-034 Without the macro, the counter logic shall be absent, to_err shall be tied to 0, and the grant is held indefinitely.

Structure
REQ-035 Package fifo_arb_pkg shall hold the FSM state enum (IDLE, GRANT) and a log2 width helper constant function.
REQ-036 One sub-module, rr_pick, shall be the combinational round-robin priority encoder: inputs req[N] and ptr; outputs gnt_idx and any.
REQ-037 The FSM, ptr, grant and timeout registers shall live in fifo_wr_arb.

Verification
REQ-038 Reset, then req_v=4'b0001, a 3-beat packet 0xA1, 0xA2, 0xA3 with last on beat 3 -> busy rises 1 cycle after req_v; 3 fifo_write pulses carry 0xA1..0xA3; busy=0 the cycle after last.
REQ-039 All 4 requesters continuously offer 1-beat packets -> grant order 0, 1, 2, 3, 0, each grant separated by one IDLE cycle.
REQ-040 Requester 2 mid-packet with fifo_full=1 for 5 cycles -> req_rdy[2]=0 and fifo_write=0 for those 5 cycles; the packet resumes with no beat lost or duplicated.
REQ-041 Requester 1 drops req_v for 3 cycles mid-packet while requester 3 is requesting -> grant stays 1; requester 3 is granted only after requester 1's last beat.
REQ-042 With FIFO_ARB_TIMEOUT_EN and TO=8, requester 0 stalls mid-packet -> to_err pulses after 8 stalled cycles, then IDLE, then requester 1 is granted if requesting. Without the macro, the same stall -> to_err stays 0 and the grant is held.
REQ-043 rst_n=0 asserted mid-packet -> next cycle busy=0 and req_rdy=0; after release, requester 0 has first priority.
